tdc_hit_scheduler: RTL and testbench

TDC_HIT_SCHEDULER -- requirements
Module: tdc_hit_scheduler

---
 rtl/tdc_hit_scheduler.sv | 158 +++++++++++++++
 tb/tb_tdc_hit_scheduler.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_hit_scheduler.sv
// TDC hit scheduler: captures encoder hits into a FIFO, inserts overflow markers, streams 33-bit words out.
// Optional TOA acceptance window enabled by defining TDC_TOA_WINDOW_EN.
`timescale 1ns/1ps
module tdc_hit_scheduler #(
  parameter int unsigned DEPTH = 8
) (
  input  logic        clk40,
  input  logic        resetn,
  input  logic        enable,
  input  logic        hitFlag,
  input  logic [9:0]  TOA_codeReg,
  input  logic [8:0]  TOT_codeReg,
  input  logic [9:0]  Cal_codeReg,
  input  logic        TOAerrorFlagReg,
  input  logic        TOTerrorFlagReg,
  input  logic        CalerrorFlagReg,
  input  logic [9:0]  winLow,
  input  logic [9:0]  winHigh,
  input  logic        doutReady,
  output logic [32:0] dout,
  output logic        doutValid,
  output logic [4:0]  fifoLevel,
  output logic [7:0]  dropCount
);

  localparam int unsigned WORD_W = 33;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned LVL_W  = 5;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_OVF} state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_cap_valid;
  logic [WORD_W-1:0]   r_cap_word;
  logic [WORD_W-1:0]   r_mem [DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [LVL_W-1:0]    r_level;
  logic [CNT_W-1:0]    r_drop_cnt;
  logic [WORD_W-1:0]   r_dout;
  logic                r_dout_valid;

  logic                w_in_win;
  logic                w_capture;
  logic                w_full;
  logic                w_pop;
  logic                w_space;
  logic                w_mark_wr;
  logic                w_hit_wr;
  logic                w_drop;
  logic                w_wr;
  logic [WORD_W-1:0]   w_wr_word;

`ifdef TDC_TOA_WINDOW_EN
  assign w_in_win = (TOA_codeReg >= winLow) && (TOA_codeReg <= winHigh);
`else
  logic [19:0] w_unused_win;
  assign w_unused_win = {winLow, winHigh};
  assign w_in_win     = 1'b1;
`endif

  // A pop frees a slot in the same edge, so a full FIFO being read can still accept a write.
  assign w_capture = hitFlag && enable && ((r_state == S_RUN) || (r_state == S_OVF)) && w_in_win;
  assign w_full    = (r_level == LVL_W'(DEPTH));
  assign w_pop     = (r_level != '0) && (!r_dout_valid || doutReady);
  assign w_space   = !w_full || w_pop;
  assign w_mark_wr = (r_state == S_OVF) && w_space;
  assign w_hit_wr  = r_cap_valid && w_space && !w_mark_wr;
  assign w_drop    = r_cap_valid && !w_hit_wr;
  assign w_wr      = w_mark_wr || w_hit_wr;
  assign w_wr_word = w_mark_wr ? {1'b1, 24'b0, r_drop_cnt} : r_cap_word;

  always_ff @(posedge clk40) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_drop)      w_next = S_OVF;
        else if (enable) w_next = S_RUN;
      end
      S_RUN: begin
        if (w_drop)       w_next = S_OVF;
        else if (!enable) w_next = S_IDLE;
      end
      S_OVF: begin
        if (w_mark_wr) w_next = enable ? S_RUN : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk40) begin
    if (!resetn) begin
      r_cap_valid <= 1'b0;
      r_cap_word  <= '0;
    end else begin
      r_cap_valid <= w_capture;
      if (w_capture)
        r_cap_word <= {1'b0, TOTerrorFlagReg, TOAerrorFlagReg, CalerrorFlagReg,
                       TOT_codeReg, TOA_codeReg, Cal_codeReg};
    end
  end

  always_ff @(posedge clk40) begin
    if (w_wr) r_mem[r_wr_ptr] <= w_wr_word;
  end

  always_ff @(posedge clk40) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // A hit losing to the marker opens the next drop epoch with a count of one.
  always_ff @(posedge clk40) begin
    if (!resetn) begin
      r_drop_cnt <= '0;
    end else if (w_mark_wr) begin
      r_drop_cnt <= w_drop ? CNT_W'(1) : CNT_W'(0);
    end else if (w_drop && (r_drop_cnt != {CNT_W{1'b1}})) begin
      r_drop_cnt <= r_drop_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk40) begin
    if (!resetn) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else if (w_pop) begin
      r_dout       <= r_mem[r_rd_ptr];
      r_dout_valid <= 1'b1;
    end else if (doutReady) begin
      r_dout_valid <= 1'b0;
    end
  end

  assign dout      = r_dout;
  assign doutValid = r_dout_valid;
  assign fifoLevel = r_level;
  assign dropCount = r_drop_cnt;

endmodule

// File: tb/tb_tdc_hit_scheduler.sv
// Directed self-checking bench for tdc_hit_scheduler (DEPTH=8).
`timescale 1ns/1ps
module tb_tdc_hit_scheduler;

  logic        clk40 = 1'b0;
  logic        resetn;
  logic        enable;
  logic        hitFlag;
  logic [9:0]  TOA_codeReg;
  logic [8:0]  TOT_codeReg;
  logic [9:0]  Cal_codeReg;
  logic        TOAerrorFlagReg;
  logic        TOTerrorFlagReg;
  logic        CalerrorFlagReg;
  logic [9:0]  winLow;
  logic [9:0]  winHigh;
  logic        doutReady;
  logic [32:0] dout;
  logic        doutValid;
  logic [4:0]  fifoLevel;
  logic [7:0]  dropCount;

  int n_checks = 0;
  int n_errors = 0;

  tdc_hit_scheduler #(.DEPTH(8)) dut (
    .clk40(clk40), .resetn(resetn), .enable(enable), .hitFlag(hitFlag),
    .TOA_codeReg(TOA_codeReg), .TOT_codeReg(TOT_codeReg), .Cal_codeReg(Cal_codeReg),
    .TOAerrorFlagReg(TOAerrorFlagReg), .TOTerrorFlagReg(TOTerrorFlagReg),
    .CalerrorFlagReg(CalerrorFlagReg), .winLow(winLow), .winHigh(winHigh),
    .doutReady(doutReady), .dout(dout), .doutValid(doutValid),
    .fifoLevel(fifoLevel), .dropCount(dropCount)
  );

  always #12.5 clk40 = ~clk40;

  task automatic check_val(input string tag, input logic [32:0] got, input logic [32:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [32:0] hword(input logic [9:0] toa, input logic [8:0] tot,
                                        input logic [9:0] cal, input logic [2:0] errs);
    return {1'b0, errs, tot, toa, cal};
  endfunction

  function automatic logic [32:0] mword(input logic [7:0] cnt);
    return {1'b1, 24'b0, cnt};
  endfunction

  task automatic tick();
    @(negedge clk40);
  endtask

  task automatic set_hit(input logic [9:0] toa, input logic [8:0] tot,
                         input logic [9:0] cal, input logic [2:0] errs);
    hitFlag         = 1'b1;
    TOA_codeReg     = toa;
    TOT_codeReg     = tot;
    Cal_codeReg     = cal;
    TOTerrorFlagReg = errs[2];
    TOAerrorFlagReg = errs[1];
    CalerrorFlagReg = errs[0];
  endtask

  initial begin
    logic        seen;
    logic [32:0] q[$];
    logic [32:0] exp_q[$];

    resetn = 1'b0; enable = 1'b0; hitFlag = 1'b0;
    TOA_codeReg = '0; TOT_codeReg = '0; Cal_codeReg = '0;
    TOAerrorFlagReg = 1'b0; TOTerrorFlagReg = 1'b0; CalerrorFlagReg = 1'b0;
    winLow = 10'd100; winHigh = 10'd200; doutReady = 1'b1;
    repeat (2) tick();
    check_val("rst_valid", 33'(doutValid), 33'd0);
    check_val("rst_dout",  dout, 33'd0);
    check_val("rst_level", 33'(fifoLevel), 33'd0);
    check_val("rst_drop",  33'(dropCount), 33'd0);
    resetn = 1'b1; enable = 1'b1;
    repeat (2) tick();

    // Single hit latency
    set_hit(10'h155, 9'h0AA, 10'h2A0, 3'b000);
    tick(); hitFlag = 1'b0;
    check_val("lat_e0_valid", 33'(doutValid), 33'd0);
    tick();
    check_val("lat_e1_valid", 33'(doutValid), 33'd0);
    tick();
    check_val("lat_e2_valid", 33'(doutValid), 33'd1);
    check_val("lat_e2_dout",  dout, hword(10'h155, 9'h0AA, 10'h2A0, 3'b000));
    tick();
    check_val("lat_e3_valid", 33'(doutValid), 33'd0);

    // Disabled capture
    enable = 1'b0;
    set_hit(10'h001, 9'h002, 10'h003, 3'b111);
    tick(); hitFlag = 1'b0;
    seen = 1'b0;
    repeat (5) begin tick(); seen |= doutValid; end
    check_val("dis_no_out", 33'(seen), 33'd0);
    enable = 1'b1;
    repeat (2) tick();

    // Overflow with 11 hits and marker recovery
    doutReady = 1'b0;
    for (int i = 0; i < 11; i++) begin
      set_hit(10'(i + 16), 9'(i), 10'(3 * i), 3'(i));
      tick();
    end
    hitFlag = 1'b0;
    repeat (3) tick();
    check_val("ovf_level", 33'(fifoLevel), 33'd8);
    check_val("ovf_valid", 33'(doutValid), 33'd1);
    check_val("ovf_dout0", dout, hword(10'd16, 9'd0, 10'd0, 3'd0));
    check_val("ovf_drop",  33'(dropCount), 33'd2);
    doutReady = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      check_val("ovf_drain_valid", 33'(doutValid), 33'd1);
      check_val("ovf_drain_dout", dout,
                (k < 9) ? hword(10'(k + 16), 9'(k), 10'(3 * k), 3'(k)) : mword(8'd2));
      if (k == 1) check_val("ovf_drop_clr", 33'(dropCount), 33'd0);
    end
    tick();
    check_val("ovf_end_valid", 33'(doutValid), 33'd0);
    check_val("ovf_end_level", 33'(fifoLevel), 33'd0);
    set_hit(10'h3FF, 9'h1FF, 10'h3FF, 3'b010);
    tick(); hitFlag = 1'b0;
    repeat (2) tick();
    check_val("run_after_ovf", dout, hword(10'h3FF, 9'h1FF, 10'h3FF, 3'b010));
    check_val("run_after_ovf_drop", 33'(dropCount), 33'd0);
    repeat (2) tick();

    // Hits every cycle stream at one word per cycle
    for (int c = 0; c <= 22; c++) begin
      if (c >= 3) begin
        check_val("strm_valid", 33'(doutValid), 33'd1);
        check_val("strm_dout", dout, hword(10'(c * 7), 9'(c + 100), 10'(c + 500), 3'(c)));
      end
      if (c >= 3 && c <= 20) check_val("strm_level", 33'(fifoLevel), 33'd1);
      if (c < 20) set_hit(10'((c + 3) * 7), 9'(c + 103), 10'(c + 503), 3'(c + 3));
      else        hitFlag = 1'b0;
      if (c < 20 && c < 3) set_hit(10'(c * 7 + 21), 9'(c + 103), 10'(c + 503), 3'(c + 3));
      tick();
    end
    check_val("strm_drop", 33'(dropCount), 33'd0);
    repeat (3) tick();

    // TOA window
    q.delete();
    for (int c = 0; c < 12; c++) begin
      if (doutValid) q.push_back(dout);
      case (c)
        0: set_hit(10'd99,  9'd1, 10'd11, 3'b000);
        1: set_hit(10'd100, 9'd2, 10'd12, 3'b000);
        2: set_hit(10'd200, 9'd3, 10'd13, 3'b000);
        3: set_hit(10'd201, 9'd4, 10'd14, 3'b000);
        default: hitFlag = 1'b0;
      endcase
      tick();
    end
    exp_q.delete();
`ifdef TDC_TOA_WINDOW_EN
    exp_q.push_back(hword(10'd100, 9'd2, 10'd12, 3'b000));
    exp_q.push_back(hword(10'd200, 9'd3, 10'd13, 3'b000));
`else
    exp_q.push_back(hword(10'd99,  9'd1, 10'd11, 3'b000));
    exp_q.push_back(hword(10'd100, 9'd2, 10'd12, 3'b000));
    exp_q.push_back(hword(10'd200, 9'd3, 10'd13, 3'b000));
    exp_q.push_back(hword(10'd201, 9'd4, 10'd14, 3'b000));
`endif
    check_val("win_count", 33'(q.size()), 33'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check_val("win_word", (i < q.size()) ? q[i] : 33'h0, exp_q[i]);

    // Drop counter saturation and marker priority over a same-cycle hit
    doutReady = 1'b0;
    for (int c = 0; c < 275; c++) begin
      set_hit(10'(c), 9'(c), 10'(c), 3'b000);
      tick();
    end
    check_val("sat_drop",  33'(dropCount), 33'd255);
    check_val("sat_level", 33'(fifoLevel), 33'd8);
    doutReady = 1'b1;
    tick();
    hitFlag = 1'b0;
    check_val("prio_drop",  33'(dropCount), 33'd1);
    check_val("prio_level", 33'(fifoLevel), 33'd8);
    check_val("prio_dout",  dout, hword(10'd1, 9'd1, 10'd1, 3'b000));
    repeat (8) tick();
    check_val("sat_marker", dout, mword(8'hFF));
    repeat (12) tick();
    check_val("sat_end_level", 33'(fifoLevel), 33'd0);

    // Reset while five words are queued and one is presented
    doutReady = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_hit(10'(i + 40), 9'(i), 10'(i), 3'b001);
      tick();
    end
    hitFlag = 1'b0;
    repeat (3) tick();
    check_val("mid_level", 33'(fifoLevel), 33'd5);
    check_val("mid_valid", 33'(doutValid), 33'd1);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    check_val("mid_rst_valid", 33'(doutValid), 33'd0);
    check_val("mid_rst_level", 33'(fifoLevel), 33'd0);
    check_val("mid_rst_drop",  33'(dropCount), 33'd0);
    check_val("mid_rst_dout",  dout, 33'd0);
    repeat (2) tick();
    doutReady = 1'b1;
    set_hit(10'h0F0, 9'h10F, 10'h00F, 3'b100);
    tick(); hitFlag = 1'b0;
    repeat (2) tick();
    check_val("post_rst_valid", 33'(doutValid), 33'd1);
    check_val("post_rst_dout",  dout, hword(10'h0F0, 9'h10F, 10'h00F, 3'b100));
    tick();
    check_val("post_rst_level", 33'(fifoLevel), 33'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
